uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_tx_drain.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_drain.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains characters from a TX buffer and serialises them as
// UART frames (start, DATA_WIDTH data bits LSB first, optional parity,
// one or two stop bits). Every output comes straight from a flop.
module uart_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  clks_per_bit_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  input  logic                  buf_empty_i,
  input  logic [DATA_WIDTH-1:0] buf_rdata_i,
  output logic                  buf_re_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_N    = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE_N    = DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  n_q, n_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  re_q, re_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DIV_WIDTH-1:0]  n_eff;
  logic                  bit_end;
  logic                  stop_last;
  logic                  start_ok;

  // A divisor below 2 is clamped so every bit lasts at least two cycles.
  assign n_eff     = (clks_per_bit_i < MIN_N) ? MIN_N : clks_per_bit_i;
  assign bit_end   = (baud_q == '0);
  assign stop_last = (bit_q == BIT_W'(stop2_q));
  assign start_ok  = en_i & ~buf_empty_i;

  // Next-state, counter and datapath logic; output values are derived from
  // the next state so the output flops line up with the state register.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        state_d   = START;
        shift_d   = buf_rdata_i;
        n_d       = n_eff;
        baud_d    = n_eff - ONE_N;
        bit_d     = '0;
        par_en_d  = parity_en_i;
        par_bit_d = (^buf_rdata_i) ^ parity_odd_i;
        stop2_d   = stop2_i;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = n_q - ONE_N;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - ONE_N;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = n_q - ONE_N;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q - ONE_N;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          baud_d  = n_q - ONE_N;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - ONE_N;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_last) begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = start_ok ? FETCH : IDLE;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            baud_d = n_q - ONE_N;
          end
        end else begin
          baud_d = baud_q - ONE_N;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase

    re_d   = (state_d == FETCH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == '0) && (bit_d == BIT_W'(stop2_d));
  end

  // State, counters, latched frame settings and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      n_q       <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign buf_re_o = re_q;
  assign tx_o     = tx_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: drives uart_tx_drain from a queue-backed TX buffer and
// compares every cycle against a frame-level reference timeline.
module tb_uart_tx_drain;

  localparam int DW   = 8;
  localparam int DIVW = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            en_i;
  logic [DIVW-1:0] clks_per_bit_i;
  logic            parity_en_i;
  logic            parity_odd_i;
  logic            stop2_i;
  logic            buf_empty_i = 1'b1;
  logic [DW-1:0]   buf_rdata_i = '0;
  logic            buf_re_o;
  logic            tx_o;
  logic            busy_o;
  logic            done_o;

  uart_tx_drain #(
    .DATA_WIDTH(DW),
    .DIV_WIDTH (DIVW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .clks_per_bit_i(clks_per_bit_i),
    .parity_en_i   (parity_en_i),
    .parity_odd_i  (parity_odd_i),
    .stop2_i       (stop2_i),
    .buf_empty_i   (buf_empty_i),
    .buf_rdata_i   (buf_rdata_i),
    .buf_re_o      (buf_re_o),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic tx;
    logic busy;
    logic re;
    logic done;
    bit   isLoad;
  } expT;

  expT           expQ[$];
  expT           cur;
  logic [DW-1:0] bufQ[$];
  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] curByte;

  int assertCount = 0;
  int failCount   = 0;
  int reCount     = 0;
  int doneCount   = 0;
  int busyCount   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Expected line activity of one frame, built from the bit list: start,
  // data LSB first, optional parity, stop bit(s), each lasting N cycles.
  function automatic void buildFrame(input logic [DW-1:0] data);
    int   n;
    bit   bits[$];
    expT  e;
    n = (clks_per_bit_i < 2) ? 2 : int'(clks_per_bit_i);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(data[i]);
    if (parity_en_i) bits.push_back(parity_odd_i ? ~(^data) : (^data));
    bits.push_back(1'b1);
    if (stop2_i) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int k = 0; k < n; k++) begin
        e.tx = bits[b]; e.busy = 1'b1; e.re = 1'b0; e.done = 1'b0; e.isLoad = 1'b0;
        expQ.push_back(e);
      end
    end
    expQ[expQ.size()-1].done = 1'b1;
  endfunction

  // Buffer model, per-cycle comparison and frame scheduling, all away from
  // the rising edge so inputs and outputs are stable.
  always @(negedge clk_i) begin
    if (rst_ni && buf_re_o && bufQ.size() > 0) buf_rdata_i = bufQ.pop_front();
    buf_empty_i = (bufQ.size() == 0);
    if (!rst_ni) begin
      expQ.delete();
      checkOutput("rst_tx",   32'(tx_o),     32'd1);
      checkOutput("rst_busy", 32'(busy_o),   32'd0);
      checkOutput("rst_re",   32'(buf_re_o), 32'd0);
      checkOutput("rst_done", 32'(done_o),   32'd0);
    end else begin
      if (expQ.size() > 0) cur = expQ.pop_front();
      else begin
        cur.tx = 1'b1; cur.busy = 1'b0; cur.re = 1'b0; cur.done = 1'b0; cur.isLoad = 1'b0;
      end
      checkOutput("tx",   32'(tx_o),     32'(cur.tx));
      checkOutput("busy", 32'(busy_o),   32'(cur.busy));
      checkOutput("re",   32'(buf_re_o), 32'(cur.re));
      checkOutput("done", 32'(done_o),   32'(cur.done));
      if (buf_re_o) reCount++;
      if (done_o) doneCount++;
      if (busy_o) busyCount++;
      if (cur.isLoad) buildFrame(curByte);
      if (expQ.size() == 0 && en_i && !buf_empty_i && modelQ.size() > 0) begin
        curByte = modelQ.pop_front();
        cur.tx = 1'b1; cur.busy = 1'b1; cur.re = 1'b1; cur.done = 1'b0; cur.isLoad = 1'b0;
        expQ.push_back(cur);
        cur.re = 1'b0; cur.isLoad = 1'b1;
        expQ.push_back(cur);
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [DIVW-1:0] cpb,
                               input logic pe, input logic po, input logic s2);
    @(posedge clk_i);
    #1;
    en_i           = en;
    clks_per_bit_i = cpb;
    parity_en_i    = pe;
    parity_odd_i   = po;
    stop2_i        = s2;
  endtask

  task automatic pushByte(input logic [DW-1:0] b);
    bufQ.push_back(b);
    modelQ.push_back(b);
  endtask

  task automatic waitDrain(input int maxCycles, input bit needEmpty);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxCycles && !ok; i++) begin
      @(posedge clk_i);
      #1;
      if (expQ.size() == 0 && (!needEmpty || bufQ.size() == 0)) ok = 1'b1;
    end
    checkOutput("drain_timeout", 32'(ok), 32'd1);
  endtask

  int r0, d0, b0;

  // Directed scenarios followed by a randomized soak and final drain.
  initial begin
    rst_ni = 1'b0; en_i = 1'b0; clks_per_bit_i = DIVW'(4);
    parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
    #12;
    checkOutput("reset_tx",   32'(tx_o),     32'd1);
    checkOutput("reset_busy", 32'(busy_o),   32'd0);
    checkOutput("reset_re",   32'(buf_re_o), 32'd0);
    checkOutput("reset_done", 32'(done_o),   32'd0);
    @(posedge clk_i); #2; rst_ni = 1'b1;

    $display("[TB] N=4 8N1 0x55");
    applyStimulus(1'b1, DIVW'(4), 1'b0, 1'b0, 1'b0);
    r0 = reCount; d0 = doneCount; b0 = busyCount;
    pushByte(8'h55);
    waitDrain(200, 1'b1);
    checkOutput("t1_re_pulses",   32'(reCount - r0),   32'd1);
    checkOutput("t1_done_pulses", 32'(doneCount - d0), 32'd1);
    checkOutput("t1_busy_cycles", 32'(busyCount - b0), 32'd42);

    $display("[TB] N=2 even and odd parity on 0x07");
    applyStimulus(1'b1, DIVW'(2), 1'b1, 1'b0, 1'b0);
    b0 = busyCount;
    pushByte(8'h07);
    waitDrain(200, 1'b1);
    checkOutput("t2_even_busy", 32'(busyCount - b0), 32'd24);
    applyStimulus(1'b1, DIVW'(2), 1'b1, 1'b1, 1'b0);
    b0 = busyCount;
    pushByte(8'h07);
    waitDrain(200, 1'b1);
    checkOutput("t2_odd_busy", 32'(busyCount - b0), 32'd24);

    $display("[TB] divisor 0 with two stop bits");
    applyStimulus(1'b1, DIVW'(0), 1'b0, 1'b0, 1'b1);
    b0 = busyCount;
    pushByte(8'h9A);
    waitDrain(200, 1'b1);
    checkOutput("t3_busy", 32'(busyCount - b0), 32'd24);

    $display("[TB] three queued bytes back to back");
    applyStimulus(1'b1, DIVW'(3), 1'b0, 1'b0, 1'b0);
    r0 = reCount; d0 = doneCount; b0 = busyCount;
    pushByte(8'h11); pushByte(8'h22); pushByte(8'h33);
    waitDrain(400, 1'b1);
    checkOutput("t4_re_pulses",   32'(reCount - r0),   32'd3);
    checkOutput("t4_done_pulses", 32'(doneCount - d0), 32'd3);
    checkOutput("t4_busy_cycles", 32'(busyCount - b0), 32'd96);

    $display("[TB] enable dropped during data bits");
    applyStimulus(1'b1, DIVW'(3), 1'b0, 1'b0, 1'b0);
    r0 = reCount; d0 = doneCount;
    pushByte(8'h3C); pushByte(8'hC3);
    repeat (9) @(posedge clk_i);
    applyStimulus(1'b0, DIVW'(3), 1'b0, 1'b0, 1'b0);
    waitDrain(200, 1'b0);
    repeat (5) @(posedge clk_i);
    checkOutput("t5_re_pulses",   32'(reCount - r0),   32'd1);
    checkOutput("t5_done_pulses", 32'(doneCount - d0), 32'd1);
    applyStimulus(1'b1, DIVW'(3), 1'b0, 1'b0, 1'b0);
    waitDrain(200, 1'b1);

    $display("[TB] reset pulsed during data bits");
    applyStimulus(1'b1, DIVW'(4), 1'b0, 1'b0, 1'b0);
    pushByte(8'h00);
    repeat (10) @(posedge clk_i);
    #2;
    checkOutput("t6_pre_reset_tx", 32'(tx_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_async_tx",   32'(tx_o),     32'd1);
    checkOutput("t6_async_busy", 32'(busy_o),   32'd0);
    checkOutput("t6_async_re",   32'(buf_re_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    d0 = doneCount;
    pushByte(8'hF0);
    waitDrain(200, 1'b1);
    checkOutput("t6_done_after_reset", 32'(doneCount - d0), 32'd1);

    $display("[TB] randomized soak");
    for (int c = 0; c < 2500; c++) begin
      applyStimulus(1'($urandom_range(0, 9) != 0), DIVW'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 29) == 0) pushByte(DW'($urandom));
    end
    applyStimulus(1'b1, DIVW'(2), 1'b1, 1'b0, 1'b1);
    waitDrain(20000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
